// File: rtl/fft_iter_addr_gen.sv
// Butterfly pair / twiddle / write-back address generator for the iterative radix-2 FFT.
// Optional macro FFT_ADDR_BITREV_OUT_EN: bit-reversed write-back in the final stage.
module fft_iter_addr_gen #(
    parameter int LAYERS      = 5,
    parameter int BUTTERFLYES = 16,
    parameter int LayWL       = 3,
    parameter int ButtWL      = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              ADDR_RST,
    input  logic              ADDR_EN,
    input  logic              LAY_EN,
    input  logic              RAM_EN_R,
    input  logic              LAST_LAY,
    output logic [ButtWL:0]   ADDR_A,
    output logic [ButtWL:0]   ADDR_B,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [ButtWL:0]   WR_ADDR_A,
    output logic [ButtWL:0]   WR_ADDR_B,
    output logic [LayWL-1:0]  LAYER,
    output logic              DONE,
    output logic              SEQ_ERR
);

    localparam int AddrWL = ButtWL + 1;

    logic [ButtWL-1:0] butt_q, butt_d;
    logic [LayWL-1:0]  lay_q, lay_d;
    logic [AddrWL-1:0] wr_a_q, wr_a_d;
    logic [AddrWL-1:0] wr_b_q, wr_b_d;
    logic              done_q, done_d;
    logic              seq_err_q, seq_err_d;

    logic [AddrWL-1:0] low_mask, butt_ext, addr_a, addr_b;
    logic [AddrWL-1:0] cap_a, cap_b;
    logic [LayWL:0]    lay_p1;
    logic [LayWL-1:0]  tw_shift;
    logic [ButtWL-1:0] tw_addr;
    logic              butt_last, lay_last;

    // Insert a zero at bit position lay into the butterfly index; partner is 2**lay above.
    always_comb begin
        butt_ext = AddrWL'(butt_q);
        low_mask = (AddrWL'(1) << lay_q) - AddrWL'(1);
        lay_p1   = {1'b0, lay_q} + (LayWL + 1)'(1);
        addr_a   = ((butt_ext >> lay_q) << lay_p1) | (butt_ext & low_mask);
        addr_b   = addr_a + (AddrWL'(1) << lay_q);
        tw_shift = LayWL'(LAYERS - 1) - lay_q;
        tw_addr  = (butt_q & low_mask[ButtWL-1:0]) << tw_shift;
    end

    assign butt_last = (butt_q == ButtWL'(BUTTERFLYES - 1));
    assign lay_last  = (lay_q == LayWL'(LAYERS - 1));

`ifdef FFT_ADDR_BITREV_OUT_EN
    always_comb begin
        cap_a = addr_a;
        cap_b = addr_b;
        if (LAST_LAY) begin
            for (int unsigned i = 0; i < AddrWL; i++) begin
                cap_a[i] = addr_a[AddrWL-1-i];
                cap_b[i] = addr_b[AddrWL-1-i];
            end
        end
    end
`else
    always_comb begin
        cap_a = addr_a;
        cap_b = addr_b;
    end
`endif

    always_comb begin
        butt_d    = butt_q;
        lay_d     = lay_q;
        wr_a_d    = wr_a_q;
        wr_b_d    = wr_b_q;
        done_d    = done_q;
        seq_err_d = seq_err_q;
        if (EN) begin
            if (ADDR_RST) begin
                butt_d    = '0;
                lay_d     = '0;
                wr_a_d    = '0;
                wr_b_d    = '0;
                done_d    = 1'b0;
                seq_err_d = 1'b0;
            end else begin
                done_d = 1'b0;
                if (RAM_EN_R) begin
                    wr_a_d = cap_a;
                    wr_b_d = cap_b;
                end
                if (ADDR_EN) begin
                    if (!butt_last) begin
                        butt_d = butt_q + ButtWL'(1);
                    end else if (!lay_last) begin
                        butt_d = '0;
                        lay_d  = lay_q + LayWL'(1);
                    end else begin
                        butt_d = '0;
                        lay_d  = '0;
                        done_d = 1'b1;
                    end
                end
                if ((LAY_EN && (!ADDR_EN || !butt_last)) ||
                    (LAST_LAY && RAM_EN_R && !lay_last)) begin
                    seq_err_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            butt_q    <= '0;
            lay_q     <= '0;
            wr_a_q    <= '0;
            wr_b_q    <= '0;
            done_q    <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            butt_q    <= butt_d;
            lay_q     <= lay_d;
            wr_a_q    <= wr_a_d;
            wr_b_q    <= wr_b_d;
            done_q    <= done_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign ADDR_A    = addr_a;
    assign ADDR_B    = addr_b;
    assign TW_ADDR   = tw_addr;
    assign LAYER     = lay_q;
    assign WR_ADDR_A = wr_a_q;
    assign WR_ADDR_B = wr_b_q;
    assign DONE      = done_q;
    assign SEQ_ERR   = seq_err_q;

endmodule

// File: tb/tb_fft_iter_addr_gen.sv
// Directed table-driven bench for fft_iter_addr_gen, plus multi-cycle sequences.
module tb_fft_iter_addr_gen;

    logic       CLK, RST, EN, ADDR_RST, ADDR_EN, LAY_EN, RAM_EN_R, LAST_LAY;
    logic [4:0] ADDR_A, ADDR_B, WR_ADDR_A, WR_ADDR_B;
    logic [3:0] TW_ADDR;
    logic [2:0] LAYER;
    logic       DONE, SEQ_ERR;

    int total = 0;
    int bad   = 0;

    fft_iter_addr_gen #(.LAYERS(5), .BUTTERFLYES(16), .LayWL(3), .ButtWL(4)) dut (
        .CLK(CLK), .RST(RST), .EN(EN), .ADDR_RST(ADDR_RST), .ADDR_EN(ADDR_EN),
        .LAY_EN(LAY_EN), .RAM_EN_R(RAM_EN_R), .LAST_LAY(LAST_LAY),
        .ADDR_A(ADDR_A), .ADDR_B(ADDR_B), .TW_ADDR(TW_ADDR),
        .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B), .LAYER(LAYER),
        .DONE(DONE), .SEQ_ERR(SEQ_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       en, arst, aen, len, ram, last;
        logic [4:0] a, b;
        logic [3:0] tw;
        logic [2:0] lay;
        logic [4:0] wa, wb;
        logic       done, err;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input logic en, input logic arst, input logic aen,
                        input logic len, input logic ram, input logic last);
        EN = en; ADDR_RST = arst; ADDR_EN = aen; LAY_EN = len;
        RAM_EN_R = ram; LAST_LAY = last;
        @(posedge CLK);
        #1;
        EN = 1'b1; ADDR_RST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0;
        RAM_EN_R = 1'b0; LAST_LAY = 1'b0;
    endtask

    // Reference: build the address bit by bit, skipping position l for the inserted zero.
    function automatic int ref_a(input int b, input int l);
        logic [4:0] r;
        logic [3:0] bb;
        int j;
        bb = 4'(b);
        r  = '0;
        j  = 0;
        for (int i = 0; i < 5; i++) begin
            if (i != l) begin
                r[i] = bb[j];
                j++;
            end
        end
        return int'(r);
    endfunction

    task automatic pulses(input int n, input logic with_len);
        for (int i = 0; i < n; i++) begin
            step(1, 0, 1, with_len && ((i % 16) == 15), 0, 0);
        end
    endtask

    initial begin
        vec_t v;
        int   done_cnt;
        int   exp_b, exp_l;

        vecs[0] = '{"idle",        1,0,0,0,0,0, 0, 1, 0,0, 0,0, 0,0};
        vecs[1] = '{"adv1",        1,0,1,0,0,0, 2, 3, 0,0, 0,0, 0,0};
        vecs[2] = '{"adv2",        1,0,1,0,0,0, 4, 5, 0,0, 0,0, 0,0};
        vecs[3] = '{"adv3",        1,0,1,0,0,0, 6, 7, 0,0, 0,0, 0,0};
        vecs[4] = '{"adv_and_cap", 1,0,1,0,1,0, 8, 9, 0,0, 6,7, 0,0};
        vecs[5] = '{"cap",         1,0,0,0,1,0, 8, 9, 0,0, 8,9, 0,0};
        vecs[6] = '{"en_low_hold", 0,0,1,1,1,0, 8, 9, 0,0, 8,9, 0,0};
        vecs[7] = '{"lay_en_alone",1,0,0,1,0,0, 8, 9, 0,0, 8,9, 0,1};
        vecs[8] = '{"err_sticky",  1,0,0,0,0,0, 8, 9, 0,0, 8,9, 0,1};
        vecs[9] = '{"addr_rst",    1,1,1,0,1,0, 0, 1, 0,0, 0,0, 0,0};

        EN = 1; ADDR_RST = 0; ADDR_EN = 0; LAY_EN = 0; RAM_EN_R = 0; LAST_LAY = 0;
        RST = 1'b0;
        #23;
        RST = 1'b1;
        #1;
        chk("rst_addr_a", int'(ADDR_A), 0);
        chk("rst_addr_b", int'(ADDR_B), 1);
        chk("rst_done",   int'(DONE),   0);
        chk("rst_err",    int'(SEQ_ERR), 0);

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            step(v.en, v.arst, v.aen, v.len, v.ram, v.last);
            chk({v.name, ".addr_a"}, int'(ADDR_A), int'(v.a));
            chk({v.name, ".addr_b"}, int'(ADDR_B), int'(v.b));
            chk({v.name, ".tw"},     int'(TW_ADDR), int'(v.tw));
            chk({v.name, ".layer"},  int'(LAYER), int'(v.lay));
            chk({v.name, ".wr_a"},   int'(WR_ADDR_A), int'(v.wa));
            chk({v.name, ".wr_b"},   int'(WR_ADDR_B), int'(v.wb));
            chk({v.name, ".done"},   int'(DONE), int'(v.done));
            chk({v.name, ".err"},    int'(SEQ_ERR), int'(v.err));
        end

        // lay=2, butt=5 reached without LAY_EN at the wraps (not an error)
        pulses(37, 0);
        step(1, 0, 0, 0, 1, 0);
        chk("l2b5.addr_a", int'(ADDR_A), 9);
        chk("l2b5.addr_b", int'(ADDR_B), 13);
        chk("l2b5.tw",     int'(TW_ADDR), 4);
        chk("l2b5.layer",  int'(LAYER), 2);
        chk("l2b5.wr_a",   int'(WR_ADDR_A), 9);
        chk("l2b5.wr_b",   int'(WR_ADDR_B), 13);
        chk("l2b5.err",    int'(SEQ_ERR), 0);

        // full transform with LAY_EN on every wrap
        step(1, 1, 0, 0, 0, 0);
        done_cnt = 0;
        for (int i = 0; i < 80; i++) begin
            step(1, 0, 1, (i % 16) == 15, 0, 0);
            exp_b = (i + 1) % 16;
            exp_l = ((i + 1) / 16) % 5;
            if (DONE) done_cnt++;
            chk("full.layer",  int'(LAYER), exp_l);
            chk("full.addr_a", int'(ADDR_A), ref_a(exp_b, exp_l));
            chk("full.addr_b", int'(ADDR_B), ref_a(exp_b, exp_l) + (1 << exp_l));
            chk("full.done",   int'(DONE), (i == 79) ? 1 : 0);
        end
        step(1, 0, 0, 0, 0, 0);
        chk("full.done_clear", int'(DONE), 0);
        chk("full.done_count", done_cnt, 1);
        chk("full.err",        int'(SEQ_ERR), 0);
        chk("full.layer_end",  int'(LAYER), 0);

        // LAY_EN at butt=7 is a sequencing error, sticky until ADDR_RST
        pulses(7, 0);
        step(1, 0, 1, 1, 0, 0);
        chk("layen_b7.err", int'(SEQ_ERR), 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        chk("layen_b7.sticky", int'(SEQ_ERR), 1);
        step(1, 1, 0, 0, 0, 0);
        chk("layen_b7.rst_err",   int'(SEQ_ERR), 0);
        chk("layen_b7.rst_a",     int'(ADDR_A), 0);
        chk("layen_b7.rst_layer", int'(LAYER), 0);

        // LAST_LAY during read phase of a non-final stage
        step(1, 0, 0, 0, 1, 1);
        chk("lastlay_early.err", int'(SEQ_ERR), 1);
        step(1, 1, 0, 0, 0, 0);

        // ADDR_RST mid-transform: no DONE, back to layer 0
        pulses(40, 1);
        step(1, 1, 1, 0, 0, 0);
        chk("midrst.layer", int'(LAYER), 0);
        chk("midrst.done",  int'(DONE), 0);
        chk("midrst.addr_b", int'(ADDR_B), 1);

        // final stage capture, lay=4 butt=5
        pulses(69, 1);
        step(1, 0, 0, 0, 1, 1);
        chk("last.layer",  int'(LAYER), 4);
        chk("last.addr_a", int'(ADDR_A), 5);
        chk("last.addr_b", int'(ADDR_B), 21);
        chk("last.tw",     int'(TW_ADDR), 5);
`ifdef FFT_ADDR_BITREV_OUT_EN
        chk("last.wr_a", int'(WR_ADDR_A), 20);
`else
        chk("last.wr_a", int'(WR_ADDR_A), 5);
`endif
        chk("last.wr_b", int'(WR_ADDR_B), 21);
        chk("last.err",  int'(SEQ_ERR), 0);

        // asynchronous reset mid-cycle
        #3;
        RST = 1'b0;
        #1;
        chk("async_rst.layer", int'(LAYER), 0);
        chk("async_rst.wr_b",  int'(WR_ADDR_B), 0);
        RST = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
